// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and coin valuation for the vending controller
package vend_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_code_e;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    VEND    = 2'b01,
    CHANGE  = 2'b10
  } state_e;

  // Coin value in nickel units; NONE is worth nothing.
  function automatic logic [2:0] coin_value(coin_code_e code);
    case (code)
      NICKEL:  coin_value = 3'd1;
      DIME:    coin_value = 3'd2;
      QUARTER: coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_hold_timer.sv
// rtl/vend_hold_timer.sv - loadable down-counter with done flag for the dispense hold
module vend_hold_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin collect / vend / change FSM for the vending machine
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE           = 5,
  parameter int MAX_CREDIT      = 15,
  parameter int DISPENSE_CYCLES = 4,
  localparam int CW             = $clog2(MAX_CREDIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_valid,
  input  logic [1:0]    coin_code,
  input  logic          cancel,
  input  logic          change_ack,
  output logic          dispense,
  output logic          change_valid,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int TW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  state_e      state;
  logic        coin_in;
  logic [CW:0] n_sum;
  logic        over_max;
  logic        reach_price;
  logic        timer_load;
  logic        timer_done;

  // One extra bit so an overflowing coin is caught instead of wrapping.
  assign coin_in     = coin_valid && (coin_code != 2'b00);
  assign n_sum       = {1'b0, credit} + (CW+1)'(coin_value(coin_code_e'(coin_code)));
  assign over_max    = n_sum > (CW+1)'(MAX_CREDIT);
  assign reach_price = n_sum >= (CW+1)'(PRICE);
  assign timer_load  = (state == COLLECT) && !cancel && coin_in && !over_max && reach_price;

  vend_hold_timer #(
    .W(TW)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TW'(DISPENSE_CYCLES - 1)),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      credit       <= '0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      case (state)
        COLLECT: begin
          if (cancel) begin
            coin_reject <= coin_in;
            if (credit != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              busy         <= 1'b1;
            end
          end else if (coin_in) begin
            if (over_max) begin
              coin_reject <= 1'b1;
            end else if (reach_price) begin
              credit   <= CW'(n_sum - (CW+1)'(PRICE));
              state    <= VEND;
              dispense <= 1'b1;
              busy     <= 1'b1;
            end else begin
              credit <= n_sum[CW-1:0];
            end
          end
        end
        VEND: begin
          coin_reject <= coin_in;
          if (timer_done) begin
            dispense <= 1'b0;
            if (credit != '0) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
            end else begin
              state <= COLLECT;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_in;
          if (change_valid && change_ack) begin
            credit <= credit - 1'b1;
            if (credit == CW'(1)) begin
              change_valid <= 1'b0;
              state        <= COLLECT;
              busy         <= 1'b0;
            end
          end
        end
        default: begin
          state        <= COLLECT;
          dispense     <= 1'b0;
          change_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       cancel;
  logic       change_ack;

  logic       dispense, change_valid, coin_reject, busy;
  logic [3:0] credit;
  logic       h_dispense, h_change_valid, h_coin_reject, h_busy;
  logic [3:0] h_credit;

  int checks = 0;
  int errors = 0;

  vend_controller #(.PRICE(5), .MAX_CREDIT(15), .DISPENSE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
    .cancel(cancel), .change_ack(change_ack), .dispense(dispense),
    .change_valid(change_valid), .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  vend_controller #(.PRICE(15), .MAX_CREDIT(15), .DISPENSE_CYCLES(4)) dut_hi (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_code(coin_code),
    .cancel(cancel), .change_ack(change_ack), .dispense(h_dispense),
    .change_valid(h_change_valid), .coin_reject(h_coin_reject), .credit(h_credit), .busy(h_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    tick();
    coin_valid = 1'b0;
    coin_code  = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Entered while the first dispense cycle is being sampled.
  task automatic vend_hold(input string tag, input int exp_credit, input int exp_cv_after);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_disp"}, dispense, 1);
      check({tag, "_cred"}, credit, exp_credit);
      check({tag, "_busy"}, busy, 1);
      tick();
    end
    check({tag, "_disp_end"}, dispense, 0);
    check({tag, "_cv_end"}, change_valid, exp_cv_after);
    check({tag, "_busy_end"}, busy, exp_cv_after);
  endtask

  initial begin
    rst_n      = 1'b0;
    coin_valid = 1'b0;
    coin_code  = 2'b00;
    cancel     = 1'b0;
    change_ack = 1'b0;
    #1;
    check("rst_credit", credit, 0);
    check("rst_dispense", dispense, 0);
    check("rst_busy", busy, 0);
    check("rst_cv", change_valid, 0);
    check("rst_reject", coin_reject, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: five nickels
    for (int i = 1; i <= 4; i++) begin
      coin(2'b01);
      check("t1_credit", credit, i);
      check("t1_busy", busy, 0);
    end
    coin(2'b01);
    vend_hold("t1", 0, 0);

    // 2: dime then quarter, change paid with a stall
    coin(2'b10);
    check("t2_credit_dime", credit, 2);
    coin(2'b11);
    vend_hold("t2", 2, 1);
    check("t2_credit_chg", credit, 2);
    tick();
    check("t2_stall", credit, 2);
    change_ack = 1'b1;
    tick();
    check("t2_ack1", credit, 1);
    check("t2_cv1", change_valid, 1);
    change_ack = 1'b0;
    tick();
    check("t2_stall2", credit, 1);
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    check("t2_ack2", credit, 0);
    check("t2_cv_done", change_valid, 0);
    check("t2_busy_done", busy, 0);

    // 3: cancel beats a simultaneous dime
    coin(2'b10);
    coin(2'b01);
    check("t3_credit", credit, 3);
    cancel = 1'b1;
    coin(2'b10);
    cancel = 1'b0;
    check("t3_reject", coin_reject, 1);
    check("t3_busy", busy, 1);
    check("t3_cv", change_valid, 1);
    check("t3_credit_kept", credit, 3);
    change_ack = 1'b1;
    tick();
    check("t3_reject_off", coin_reject, 0);
    check("t3_ack1", credit, 2);
    tick();
    check("t3_ack2", credit, 1);
    tick();
    change_ack = 1'b0;
    check("t3_ack3", credit, 0);
    check("t3_busy_done", busy, 0);

    // 4: coins rejected during VEND and CHANGE
    coin(2'b10);
    coin(2'b10);
    coin(2'b10);
    check("t4_vend_disp", dispense, 1);
    check("t4_vend_cred", credit, 1);
    coin(2'b11);
    check("t4_rej_vend", coin_reject, 1);
    check("t4_disp2", dispense, 1);
    check("t4_cred2", credit, 1);
    tick();
    check("t4_rej_off", coin_reject, 0);
    check("t4_disp3", dispense, 1);
    tick();
    check("t4_disp4", dispense, 1);
    tick();
    check("t4_disp_end", dispense, 0);
    check("t4_cv", change_valid, 1);
    coin(2'b01);
    check("t4_rej_chg", coin_reject, 1);
    check("t4_cred_chg", credit, 1);
    tick();
    check("t4_rej_chg_off", coin_reject, 0);
    change_ack = 1'b1;
    tick();
    change_ack = 1'b0;
    check("t4_cred_done", credit, 0);
    check("t4_busy_done", busy, 0);

    // 5: PRICE=15 instance, overflow reject then exact price
    do_reset();
    coin(2'b11);
    coin(2'b11);
    coin(2'b10);
    coin(2'b10);
    check("t5_cred14", h_credit, 14);
    coin(2'b11);
    check("t5_reject", h_coin_reject, 1);
    check("t5_cred_kept", h_credit, 14);
    check("t5_busy_idle", h_busy, 0);
    coin(2'b01);
    for (int i = 0; i < 4; i++) begin
      check("t5_disp", h_dispense, 1);
      check("t5_cred0", h_credit, 0);
      tick();
    end
    check("t5_disp_end", h_dispense, 0);
    check("t5_busy_end", h_busy, 0);
    check("t5_cv_end", h_change_valid, 0);

    // 6: asynchronous reset in the 2nd dispense cycle
    do_reset();
    coin(2'b11);
    check("t6_disp1", dispense, 1);
    tick();
    check("t6_disp2", dispense, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_disp", dispense, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_cred", credit, 0);
    tick();
    rst_n = 1'b1;
    coin(2'b01);
    check("t6_after", credit, 1);
    check("t6_after_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
Sequential controller for the vending machine. It accepts coin events, holds credit in nickel units, and fires the dispense mechanism for a fixed number of cycles once the price is reached. It then pays out change one nickel per handshake. It sits between the coin acceptor front end and the dispense/change-return actuators, and replaces the open-loop next-state decode with a clocked, parameterised FSM.

Parameters:
PRICE, 5, item price in nickel units (5 = 25c); must be 1..MAX_CREDIT
MAX_CREDIT, 15, largest credit held, in nickels; CW = $clog2(MAX_CREDIT+1)
DISPENSE_CYCLES, 4, cycles dispense is held high per vend; must be ≥1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
coin_valid  input  1  one-cycle coin event strobe
coin_code  input  2  00 none, 01 nickel (1), 10 dime (2), 11 quarter (5)
cancel  input  1  level; request refund of current credit
change_ack  input  1  change mechanism has taken one nickel
dispense  output  1  dispense actuator drive
change_valid  output  1  one nickel of change is offered
coin_reject  output  1  one-cycle pulse: last coin was returned, not credited
credit  output  CW  current credit in nickels
busy  output  1  high in VEND or CHANGE

Behaviour:
- Clocking and reset: one clock. rst_n is asynchronous, active-low. While rst_n=0: state=COLLECT, credit=0, dispense=0, change_valid=0, coin_reject=0, busy=0, dispense timer=0. Reset mid-vend or mid-change abandons the operation. Lost credit is not recovered.
- All outputs are registered or decoded directly from state/credit. There is no combinational input-to-output path.
- Coin value: the value of coin_code. coin_valid with coin_code=00 is ignored, with no reject.
- COLLECT:
  - cancel=1 and credit>0: go to CHANGE next cycle.
  - cancel=1 and credit=0: no action.
  - cancel=1 in the same cycle as a valid coin: cancel wins, and the coin is rejected (coin_reject=1 next cycle).
  - Otherwise, on a valid coin let n = credit + value.
  - If n > MAX_CREDIT: coin_reject pulses next cycle and credit is unchanged.
  - If n ≥ PRICE: next cycle credit = n − PRICE, state=VEND, dispense=1, timer loaded with DISPENSE_CYCLES−1.
  - Otherwise: credit = n next cycle.
- VEND:
  - dispense=1 for exactly DISPENSE_CYCLES consecutive cycles.
  - Any valid coin is rejected (coin_reject pulse next cycle). cancel is ignored.
  - On the last dispense cycle: next state is CHANGE if credit>0, else COLLECT.
- CHANGE:
  - change_valid=1 whenever credit>0.
  - A cycle with change_valid & change_ack decrements credit by 1.
  - An ack while credit=1 means next cycle credit=0, change_valid=0, state=COLLECT.
  - change_ack low stalls indefinitely. change_ack when change_valid=0 is ignored.
  - Coins are rejected. cancel is ignored.
- busy = (state != COLLECT).
- Credit arithmetic is done at width CW+1 before the overflow compare, so there is no silent wrap.

Decomposition:
- Package vend_pkg:
  - coin_code_e enum (NONE, NICKEL, DIME, QUARTER)
  - state_e enum (COLLECT, VEND, CHANGE)
  - function coin_value(coin_code_e) returning nickel units
- One sub-module, vend_hold_timer: a loadable down-counter with done flag, used for the dispense hold.

Test Plan:
Defaults (PRICE=5, MAX_CREDIT=15, DISPENSE_CYCLES=4) unless stated.
1. Five nickels on successive cycles -> credit 1,2,3,4. Cycle after the 5th coin: dispense=1 for 4 cycles, credit=0, busy=1. Then COLLECT with change_valid never asserted.
2. Dime then quarter -> credit 2, then 7≥5, so dispense ×4 with credit=2. Then change_valid=1. Two acks (one cycle gap with ack low holds credit=2) -> credit 1, 0. change_valid drops, busy=0.
3. credit=3, cancel and a dime in the same cycle -> coin_reject pulse next cycle, CHANGE entered. Three acks -> credit 0, back in COLLECT.
4. Quarter during VEND, and nickel during CHANGE -> each produces a one-cycle coin_reject. credit and dispense length are unaffected.
5. PRICE=15: drive credit to 14, then a quarter -> coin_reject, credit stays 14. Then a nickel -> 15 ≥ 15, dispense ×4, credit 0.
6. rst_n asserted asynchronously (between edges) in the 2nd dispense cycle -> dispense, busy and credit go to 0 immediately. After release, one nickel gives credit=1.
